// File: rtl/rf_scoreboard_bank.sv
// rf_scoreboard_bank
// Register file with a per-register pending (scoreboard) bit for hazard detection.
// Provides NUM_RD combinational read ports, one synchronous write port, an unbypassed
// debug read port and a hardwired-zero r0. A pending bit is set when a writer issues
// and is cleared when its writeback lands. If both happen to the same register on the
// same edge, the set wins. o_pend_cnt is a registered count of the pending bits.
//
// Optional feature: define RF_BYPASS_EN to forward the write port to the read ports
// (write-first) in the same cycle.
//
// Ports:
//   i_clk        clock; all state updates on posedge
//   i_rst_n      asynchronous reset, active-low
//   i_ra         read addresses; port i = i_ra[i*ADDR_W +: ADDR_W]
//   o_rd         read data;      port i = o_rd[i*DATA_W +: DATA_W]
//   o_rbusy      port i: register i_ra[i] has a pending write
//   i_wa/i_wd/i_we        write address / data / enable
//   i_iss_en/i_iss_addr   issue strobe and destination register to mark pending
//   o_pend_cnt   number of registers currently pending
//   i_debug_ra/o_debug_rd debug read address / data (never bypassed)
module rf_scoreboard_bank #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   i_ra,
    output logic [NUM_RD*DATA_W-1:0]   o_rd,
    output logic [NUM_RD-1:0]          o_rbusy,
    input  logic [ADDR_W-1:0]          i_wa,
    input  logic [DATA_W-1:0]          i_wd,
    input  logic                       i_we,
    input  logic                       i_iss_en,
    input  logic [ADDR_W-1:0]          i_iss_addr,
    output logic [ADDR_W:0]            o_pend_cnt,
    input  logic [ADDR_W-1:0]          i_debug_ra,
    output logic [DATA_W-1:0]          o_debug_rd
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    // r_mem[0] is never written, so it stays at its reset value of zero.
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [ADDR_W:0]   r_pend_cnt;

    logic              w_clr;
    logic              w_set;
    logic              w_inc;
    logic              w_dec;
    logic [DEPTH-1:0]  w_pend_d;
    logic [ADDR_W:0]   w_cnt_d;

    assign w_clr = i_we && (i_wa != '0);
    assign w_set = i_iss_en && (i_iss_addr != '0);

    always_comb begin
        w_pend_d = r_pend;
        if (w_clr) w_pend_d[i_wa] = 1'b0;
        // Applied second so a new producer overrides a landing writeback.
        if (w_set) w_pend_d[i_iss_addr] = 1'b1;
    end

    // Counter tracks net bit changes: a set on an already pending bit adds nothing,
    // and a clear is cancelled when the same register is re-issued on that edge.
    assign w_inc   = w_set && !r_pend[i_iss_addr];
    assign w_dec   = w_clr && r_pend[i_wa] && !(w_set && (i_iss_addr == i_wa));
    assign w_cnt_d = r_pend_cnt + (ADDR_W+1)'(w_inc) - (ADDR_W+1)'(w_dec);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            if (w_clr) r_mem[i_wa] <= i_wd;
            r_pend     <= w_pend_d;
            r_pend_cnt <= w_cnt_d;
        end
    end

    always_comb begin
        o_rd    = '0;
        o_rbusy = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            logic [ADDR_W-1:0] w_addr;
            w_addr                  = i_ra[i*ADDR_W +: ADDR_W];
            o_rd[i*DATA_W +: DATA_W] = r_mem[w_addr];
            o_rbusy[i]              = r_pend[w_addr];
`ifdef RF_BYPASS_EN
            if (w_clr && (w_addr == i_wa)) begin
                o_rd[i*DATA_W +: DATA_W] = i_wd;
                // Busy only if the same register is being re-issued this edge.
                o_rbusy[i]               = w_set && (i_iss_addr == i_wa);
            end
`endif
        end
    end

    assign o_pend_cnt = r_pend_cnt;
    assign o_debug_rd = r_mem[i_debug_ra];

endmodule

// File: tb/tb_rf_scoreboard_bank.sv
module tb_rf_scoreboard_bank;

    logic        clk;
    logic        rst_n;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rbusy;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [5:0]  pend_cnt;
    logic [4:0]  debug_ra;
    logic [31:0] debug_rd;

    rf_scoreboard_bank #(
        .DATA_W(32),
        .ADDR_W(5),
        .NUM_RD(2)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_ra       (ra),
        .o_rd       (rd),
        .o_rbusy    (rbusy),
        .i_wa       (wa),
        .i_wd       (wd),
        .i_we       (we),
        .i_iss_en   (iss_en),
        .i_iss_addr (iss_addr),
        .o_pend_cnt (pend_cnt),
        .i_debug_ra (debug_ra),
        .o_debug_rd (debug_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rd;
        logic [1:0]  rbusy;
        logic [5:0]  cnt;
        logic [31:0] dbg;
        int          tag;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model: plain arrays, one entry per architectural register.
    logic [31:0] m_reg  [32];
    bit          m_pend [32];

    function automatic void cmp(string nm, int tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s tag=%0d got=%h expected=%h", nm, tag, got, exp);
        end
    endfunction

    // Monitor: every negedge with an outstanding expectation, compare DUT outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp("rd",       e.tag, {32'h0, rd},       {32'h0, e.rd});
            cmp("rbusy",    e.tag, {62'h0, rbusy},    {62'h0, e.rbusy});
            cmp("pend_cnt", e.tag, {58'h0, pend_cnt}, {58'h0, e.cnt});
            cmp("debug_rd", e.tag, {32'h0, debug_rd}, {32'h0, e.dbg});
        end
    end

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endfunction

    // Expected combinational outputs for the inputs currently driven.
    function automatic exp_t model_expect(int tag);
        exp_t        e;
        logic [4:0]  a;
        int          n;
        n = 0;
        for (int i = 0; i < 32; i++) n += m_pend[i] ? 1 : 0;
        e.cnt   = 6'(n);
        e.dbg   = m_reg[debug_ra];
        e.tag   = tag;
        e.rd    = '0;
        e.rbusy = '0;
        for (int p = 0; p < 2; p++) begin
            a = (p == 0) ? ra[4:0] : ra[9:5];
            e.rd[p*32 +: 32] = m_reg[a];
            e.rbusy[p]       = m_pend[a];
`ifdef RF_BYPASS_EN
            if (we && wa != 0 && a == wa) begin
                e.rd[p*32 +: 32] = wd;
                e.rbusy[p]       = iss_en && iss_addr == wa;
            end
`endif
        end
        return e;
    endfunction

    // Clock edge in the model: write lands first, then the issue marks pending.
    function automatic void model_edge();
        if (we && wa != 0) begin
            m_reg[wa]  = wd;
            m_pend[wa] = 1'b0;
        end
        if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
    endfunction

    // Called just after a posedge; drives one cycle of inputs.
    task automatic step(input logic w, input logic [4:0] a_w, input logic [31:0] d_w,
                        input logic is, input logic [4:0] a_i,
                        input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a_d, input int tag);
        we = w; wa = a_w; wd = d_w;
        iss_en = is; iss_addr = a_i;
        ra = {a1, a0}; debug_ra = a_d;
        exp_q.push_back(model_expect(tag));
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    // Reset asserted mid-cycle while a write to r3 is being driven.
    task automatic reset_mid_write(input int tag);
        we = 1'b1; wa = 5'd3; wd = 32'hDEAD;
        iss_en = 1'b1; iss_addr = 5'd3;
        ra = {5'd9, 5'd3}; debug_ra = 5'd3;
        #2;
        rst_n = 1'b0;
        model_clear();
        exp_q.push_back(model_expect(tag));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        we = 0; wa = 0; wd = 0; iss_en = 0; iss_addr = 0; ra = 0; debug_ra = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset test: load r3 and r9, mark x3 pending, then reset during a write.
        step(1, 3, 32'h77, 1, 3, 3, 9, 3, 1);
        step(1, 9, 32'h11, 0, 0, 3, 9, 9, 2);
        step(0, 0, 0, 0, 0, 3, 9, 3, 3);
        reset_mid_write(4);
        step(0, 0, 0, 0, 0, 3, 9, 3, 5);

        // r0: write and issue to r0 are both ignored.
        step(1, 0, 32'h1234, 1, 0, 0, 0, 0, 10);
        step(0, 0, 0, 0, 0, 0, 0, 0, 11);

        // Hazard on x5.
        step(1, 9, 32'h11, 1, 5, 0, 0, 0, 20);
        step(1, 5, 32'hA5A5, 0, 0, 5, 9, 5, 21);
        step(0, 0, 0, 0, 0, 5, 9, 5, 22);

        // Collision on x7: set wins, count unchanged.
        step(0, 0, 0, 1, 7, 7, 0, 7, 30);
        step(1, 7, 32'd9, 1, 7, 7, 7, 7, 31);
        step(0, 0, 0, 0, 0, 7, 0, 7, 32);

        // Count saturation at 31 with re-issue and a single retire.
        for (int i = 1; i < 32; i++) step(0, 0, 0, 1, 5'(i), 5'(i), 0, 0, 40);
        step(0, 0, 0, 1, 4, 4, 1, 0, 41);
        step(1, 4, 32'h44, 0, 0, 4, 31, 4, 42);
        step(0, 0, 0, 0, 0, 4, 31, 4, 43);

        // Bypass on read port 1 (r9 currently holds 32'h11).
        step(1, 9, 32'h55, 0, 0, 0, 9, 9, 50);
        step(0, 0, 0, 0, 0, 0, 9, 9, 51);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                reset_mid_write(60);
            end else begin
                step(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                     1'($urandom_range(0, 1)), 5'($urandom),
                     5'($urandom), 5'($urandom), 5'($urandom), 100 + i);
            end
        end

        we = 0; iss_en = 0;
        repeat (3) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d pending expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
